// File: rtl/mac_unit.sv
// mac_unit: multiply-accumulate controller around a 16-bit Booth multiplier; define MAC_SAT_EN to saturate MAC overflow
module mac_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] mul_x,
  output logic [15:0] mul_y,
  input  logic [15:0] mul_z16,
  input  logic        mul_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] acc,
  output logic        ovf
);
  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;
  state_t state;
  logic is_mac;
  logic pov;
  logic add_ovf;
  logic [15:0] prod;
  logic [15:0] sum;
  logic [15:0] acc_next;
  // next accumulator value: product for MUL, wrapped or saturated signed sum for MAC
  always_comb begin
    sum = acc + prod;
    add_ovf = is_mac && (acc[15] == prod[15]) && (sum[15] != acc[15]);
`ifdef MAC_SAT_EN
    acc_next = !is_mac ? prod : add_ovf ? (acc[15] ? 16'h8000 : 16'h7fff) : sum;
`else
    acc_next = is_mac ? sum : prod;
`endif
  end
  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);
  // request accept, multiplier capture, accumulate and result hand-off sequence
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      ovf    <= 1'b0;
      mul_x  <= '0;
      mul_y  <= '0;
      prod   <= '0;
      pov    <= 1'b0;
      is_mac <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (!op[1]) begin
            mul_x  <= a;
            mul_y  <= b;
            is_mac <= op[0];
            state  <= MUL;
          end else begin
            if (!op[0]) begin
              acc <= '0;
              ovf <= 1'b0;
            end
            state <= DONE;
          end
        end
        MUL: begin
          prod  <= mul_z16;
          pov   <= mul_cout ^ mul_z16[15];
          state <= ACC;
        end
        ACC: begin
          acc   <= acc_next;
          ovf   <= ovf | pov | add_ovf;
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_unit.sv
// tb_mac_unit: directed vectors against a transaction-level accumulator model plus literal expectations
module tb_mac_unit;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic [1:0] op = 0;
  logic [15:0] a = 0, b = 0;
  logic in_ready, out_valid, mul_cout, ovf;
  logic [15:0] mul_x, mul_y, mul_z16, acc;
  int n_chk = 0, n_err = 0, cyc = 0, t_acc = 0;
  bit chk_en = 0;
  int prod_full;
  assign prod_full = $signed(mul_x) * $signed(mul_y);
  assign mul_z16  = prod_full[15:0];
  assign mul_cout = prod_full[16];

  mac_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .mul_x(mul_x), .mul_y(mul_y), .mul_z16(mul_z16), .mul_cout(mul_cout),
    .out_valid(out_valid), .out_ready(out_ready), .acc(acc), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  // transaction model: result of each request plus the cycle it becomes visible
  bit busy = 0, exp_ov = 0, m_ovf = 0;
  logic [15:0] m_acc = 0, mx = 0, my = 0, pl;
  int wait_n = 0, p, s;
  bit pv, so;
  always @(posedge clk) begin
    if (reset) begin
      busy = 0; exp_ov = 0; m_acc = 0; m_ovf = 0; mx = 0; my = 0;
    end else if (!busy) begin
      if (in_valid) begin
        busy = 1;
        if (op == 2'b10) begin m_acc = 0; m_ovf = 0; end
        if (op[1]) exp_ov = 1;
        else begin
          mx = a; my = b;
          p = $signed(a) * $signed(b);
          pl = p[15:0];
          pv = p[16] ^ p[15];
          s = $signed(m_acc) + $signed(pl);
          so = (op == 2'b01) && (s > 32767 || s < -32768);
          m_acc = (op == 2'b01) ? s[15:0] : pl;
`ifdef MAC_SAT_EN
          if (so) m_acc = (s > 0) ? 16'h7fff : 16'h8000;
`endif
          m_ovf = m_ovf | pv | so;
          wait_n = 2;
        end
      end
    end else if (exp_ov) begin
      if (out_ready) begin busy = 0; exp_ov = 0; end
    end else begin
      wait_n--;
      if (wait_n == 0) exp_ov = 1;
    end
  end

  // per-cycle comparison of the DUT against the model
  always @(negedge clk) if (chk_en) begin
    chk("in_ready", in_ready, !busy && !reset);
    chk("out_valid", out_valid, exp_ov);
    chk("mul_x", mul_x, mx);
    chk("mul_y", mul_y, my);
    if (exp_ov || !busy) begin
      chk("acc", acc, m_acc);
      chk("ovf", ovf, m_ovf);
    end
  end

  task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y, input bit keep);
    int n = 0;
    in_valid = 1; op = o; a = x; b = y;
    do begin @(negedge clk); n++; end while (!in_ready && n < 20);
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1; t_acc = cyc; #1;
    if (!keep) in_valid = 0;
  endtask

  task automatic wait_done(input logic [15:0] ea, input bit eo, input int el, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_lat"}, cyc - t_acc + 1, el);
    chk({nm, "_acc"}, acc, ea);
    chk({nm, "_ovf"}, ovf, eo);
    @(posedge clk); #2;
  endtask

  initial begin
    int t1;
    @(posedge clk); #1; chk_en = 1;
    @(negedge clk); chk("reset_in_ready", in_ready, 0);
    @(posedge clk); #2; reset = 0;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_acc", acc, 0);
    issue(2'b00, 16'h0003, 16'hfffc, 0);
    @(negedge clk);
    chk("mul_x_during_mul", mul_x, 16'h0003);
    chk("mul_y_during_mul", mul_y, 16'hfffc);
    wait_done(16'hfff4, 0, 3, "mul_neg");
    issue(2'b00, 16'h0100, 16'h0100, 0);
    wait_done(16'h0000, 1, 3, "mul_pov");
    issue(2'b11, 0, 0, 0);
    wait_done(16'h0000, 1, 1, "read");
    issue(2'b10, 0, 0, 0);
    wait_done(16'h0000, 0, 1, "clr");
    issue(2'b01, 16'h7000, 16'h0001, 0);
    wait_done(16'h7000, 0, 3, "mac_pos1");
`ifdef MAC_SAT_EN
    issue(2'b01, 16'h1000, 16'h0001, 0);
    wait_done(16'h7fff, 1, 3, "mac_pos_ovf");
    issue(2'b10, 0, 0, 0);
    wait_done(16'h0000, 0, 1, "clr2");
    issue(2'b01, 16'h9000, 16'h0001, 0);
    wait_done(16'h9000, 0, 3, "mac_neg1");
    issue(2'b01, 16'h9000, 16'h0001, 0);
    wait_done(16'h8000, 1, 3, "mac_neg_ovf");
`else
    issue(2'b01, 16'h1000, 16'h0001, 0);
    wait_done(16'h8000, 1, 3, "mac_pos_ovf");
    issue(2'b10, 0, 0, 0);
    wait_done(16'h0000, 0, 1, "clr2");
    issue(2'b01, 16'h9000, 16'h0001, 0);
    wait_done(16'h9000, 0, 3, "mac_neg1");
    issue(2'b01, 16'h9000, 16'h0001, 0);
    wait_done(16'h2000, 1, 3, "mac_neg_ovf");
`endif
    issue(2'b10, 0, 0, 0);
    wait_done(16'h0000, 0, 1, "clr3");
    out_ready = 0;
    issue(2'b01, 16'h0005, 16'h0006, 0);
    repeat (7) @(negedge clk);
    chk("hold_valid", out_valid, 1);
    chk("hold_acc", acc, 16'h001e);
    chk("hold_ovf", ovf, 0);
    chk("hold_in_ready", in_ready, 0);
    out_ready = 1;
    @(posedge clk); #2; out_ready = 0;
    @(negedge clk);
    chk("after_pulse_in_ready", in_ready, 1);
    chk("after_pulse_valid", out_valid, 0);
    out_ready = 1;
    issue(2'b10, 0, 0, 0);
    wait_done(16'h0000, 0, 1, "clr4");
    issue(2'b00, 16'h0002, 16'h0003, 1);
    t1 = t_acc;
    issue(2'b01, 16'h0004, 16'h0005, 0);
    chk("b2b_interval", t_acc - t1, 4);
    wait_done(16'h001a, 0, 3, "b2b");
    issue(2'b01, 16'h0001, 16'h0001, 0);
    @(posedge clk); #2; reset = 1;
    @(posedge clk); #2; reset = 0;
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_acc", acc, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_in_ready", in_ready, 1);
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
